// File: rtl/cpu_program_loader_if.sv
// cpu_program_loader_if
//   Bundles the loader's host byte streams and its memory port.
//   Streams:
//     in_valid/in_ready/in_data    : host -> loader program bytes
//     out_valid/out_ready/out_data : loader -> host dump bytes
//   Memory port:
//     mem_sel, mem_addr, mem_wdata, mem_we : loader -> memory
//     mem_rdata                            : memory -> loader (1-cycle latency)
//   Modports: slave = the loader, master = host/memory side.
interface cpu_program_loader_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     mem_sel;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     mem_we;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport slave (
        input  in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data, mem_sel, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data, mem_sel, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/cpu_program_loader.sv
// cpu_program_loader
//   Owns the program memory while the CPU is in reset: fills it from a byte
//   stream, releases the CPU, waits for halt_signel, then reclaims the memory
//   and streams every location back out, pulsing done at the end.
//   Ports:
//     clk, n_rst   : clock, async active-low reset
//     bus          : streams + memory port (cpu_program_loader_if.slave)
//     cpu_n_rst    : registered CPU reset, active-low
//     halt_signel  : CPU halt indication
//     done         : one-cycle pulse when the dump completes
//     timeout      : sticky, watchdog expired during the last run
//   Optional feature: define LOADER_WATCHDOG_EN to build a RUN-state cycle
//   limit of WDOG_CYCLES; otherwise RUN waits for halt forever and timeout=0.
module cpu_program_loader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 5,
    parameter int WDOG_CYCLES   = 4096
) (
    input  logic                  clk,
    input  logic                  n_rst,
    cpu_program_loader_if.slave   bus,
    output logic                  cpu_n_rst,
    input  logic                  halt_signel,
    output logic                  done,
    output logic                  timeout
);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = {ADDRESS_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_LOAD,
        S_RUN,
        S_DUMP_REQ,
        S_DUMP_CAP,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic                     cpu_n_rst_q, cpu_n_rst_d;
    logic                     run_first_q, run_first_d;  // first RUN cycle: CPU just left reset
    logic                     timeout_q, timeout_d;
    logic                     wdog_expire;

`ifdef LOADER_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Held at zero outside RUN, so it is clear on every RUN entry.
    always_comb begin
        wdog_d = '0;
        if (state_q == S_RUN) wdog_d = wdog_q + 1'b1;
    end

    // True during the WDOG_CYCLES-th RUN cycle, so RUN lasts exactly that long.
    assign wdog_expire = (state_q == S_RUN) && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end

    assign timeout = timeout_q;
`else
    assign wdog_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        out_data_d   = out_data_q;
        timeout_d    = timeout_q;
        run_first_d  = 1'b0;
        bus.in_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_sel   = 1'b1;
        bus.out_valid = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_LOAD: begin
                bus.in_ready = 1'b1;
                bus.mem_we   = bus.in_valid;
                if (bus.in_valid) begin
                    addr_d = addr_q + 1'b1;  // wraps to 0 after the last word
                    if (addr_q == LAST_ADDR) begin
                        state_d     = S_RUN;
                        run_first_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                bus.mem_sel = 1'b0;
                // Halt has priority over a simultaneous watchdog expiry.
                if (!run_first_q && halt_signel) begin
                    state_d = S_DUMP_REQ;
                end else if (wdog_expire) begin
                    state_d   = S_DUMP_REQ;
                    timeout_d = 1'b1;
                end
            end
            S_DUMP_REQ: begin
                state_d = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                out_data_d = bus.mem_rdata;  // read issued in DUMP_REQ lands now
                state_d    = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_DUMP_REQ;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                addr_d    = '0;
                timeout_d = 1'b0;
                state_d   = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
                addr_d  = '0;
            end
        endcase

        // Registered so the CPU reset changes on the same edge as the state.
        cpu_n_rst_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_LOAD;
            addr_q      <= '0;
            out_data_q  <= '0;
            cpu_n_rst_q <= 1'b0;
            run_first_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            out_data_q  <= out_data_d;
            cpu_n_rst_q <= cpu_n_rst_d;
            run_first_q <= run_first_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = bus.in_data;
    assign bus.out_data  = out_data_q;
    assign cpu_n_rst     = cpu_n_rst_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// tb_cpu_program_loader
//   Directed load/run/dump sequences against a behavioural synchronous memory.
module tb_cpu_program_loader;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic halt_signel = 1'b0;
    logic cpu_n_rst, done, timeout;

    int total = 0;
    int bad   = 0;

    logic [7:0] img [DEPTH];
    logic [7:0] mem [DEPTH];

    always #5 clk = ~clk;

    cpu_program_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    cpu_program_loader #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WDOG_CYCLES(16)
    ) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus), .cpu_n_rst(cpu_n_rst),
        .halt_signel(halt_signel), .done(done), .timeout(timeout)
    );

    // Synchronous memory, read data valid one cycle after the address.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_in_ready"},  32'(bus.in_ready),  1);
        chk({pfx, "_mem_sel"},   32'(bus.mem_sel),   1);
        chk({pfx, "_mem_we"},    32'(bus.mem_we),    0);
        chk({pfx, "_mem_addr"},  32'(bus.mem_addr),  0);
        chk({pfx, "_out_data"},  32'(bus.out_data),  0);
        chk({pfx, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({pfx, "_cpu_n_rst"}, 32'(cpu_n_rst),     0);
        chk({pfx, "_done"},      32'(done),          0);
        chk({pfx, "_timeout"},   32'(timeout),       0);
    endtask

    task automatic set_img(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            case (kind)
                0:       img[i] = 8'(8'hA0 + i);
                1:       img[i] = 8'h5A ^ 8'(i);
                2:       img[i] = 8'(8'h30 + 3 * i);
                default: img[i] = 8'hC3 ^ ~8'(i);
            endcase
        end
    endtask

    // Returns mid-way through RUN cycle 1 (negedge after the last load edge).
    task automatic load_img(input logic halt_during);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            halt_signel  = halt_during;
            bus.in_valid = 1'b1;
            bus.in_data  = img[i];
            #1;
            chk("load_in_ready", 32'(bus.in_ready), 1);
            chk("load_mem_we",   32'(bus.mem_we),   1);
            chk("load_mem_addr", 32'(bus.mem_addr), 32'(i));
            chk("load_cpu_rst",  32'(cpu_n_rst),    0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("run_cpu_n_rst", 32'(cpu_n_rst),    1);
        chk("run_mem_sel",   32'(bus.mem_sel),  0);
        chk("run_in_ready",  32'(bus.in_ready), 0);
    endtask

    // Collects the dump. bp_idx: byte held with out_ready=0; rst_idx: byte at
    // which reset is applied (task returns after releasing it).
    task automatic dump_img(input int bp_idx, input int rst_idx, input logic exp_to);
        int got = 0;
        int cyc = 0;
        bus.out_ready = 1'b0;
        while (got < DEPTH && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            #1;
            if (bus.out_valid) begin
                if (got == rst_idx) begin
                    bus.out_ready = 1'b0;
                    n_rst = 1'b0;
                    #1;
                    chk_reset_vals("midreset");
                    @(negedge clk);
                    n_rst = 1'b1;
                    return;
                end
                chk("dump_data", 32'(bus.out_data), 32'(img[got]));
                if (got == bp_idx) begin
                    repeat (10) begin
                        @(negedge clk);
                        #1;
                        chk("bp_out_valid", 32'(bus.out_valid), 1);
                        chk("bp_out_data",  32'(bus.out_data),  32'(img[got]));
                    end
                end
                bus.out_ready = 1'b1;
                got++;
            end else begin
                bus.out_ready = 1'b0;
            end
        end
        chk("dump_count", 32'(got), 32'(DEPTH));
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        chk("done_pulse",     32'(done),          1);
        chk("done_out_valid", 32'(bus.out_valid), 0);
        chk("done_timeout",   32'(timeout),       32'(exp_to));
        @(negedge clk);
        #1;
        chk("post_done",      32'(done),          0);
        chk("post_in_ready",  32'(bus.in_ready),  1);
        chk("post_mem_addr",  32'(bus.mem_addr),  0);
        chk("post_timeout",   32'(timeout),       0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // Image 1: halt held during LOAD and in RUN cycle 1, low in cycle 2,
        // high from cycle 3; backpressure on dump byte 5.
        set_img(0);
        load_img(1'b1);
        @(negedge clk);
        halt_signel = 1'b0;
        #1;
        chk("halt_c1_ignored", 32'(bus.mem_sel), 0);
        @(negedge clk);
        halt_signel = 1'b1;
        #1;
        chk("run_c2_no_halt", 32'(bus.mem_sel), 0);
        @(negedge clk);
        #1;
        chk("halt_cpu_n_rst", 32'(cpu_n_rst),    0);
        chk("halt_mem_sel",   32'(bus.mem_sel),  1);
        chk("dreq_mem_we",    32'(bus.mem_we),   0);
        chk("dreq_mem_addr",  32'(bus.mem_addr), 0);
        dump_img(5, -1, 1'b0);
        halt_signel = 1'b0;

        // Image 2, straight after done: halt in RUN cycle 2.
        set_img(1);
        load_img(1'b0);
        @(negedge clk);
        halt_signel = 1'b1;
        #1;
        chk("img2_run_c2", 32'(bus.mem_sel), 0);
        @(negedge clk);
        halt_signel = 1'b0;
        #1;
        chk("img2_dump_req", 32'(bus.mem_sel), 1);
        dump_img(-1, -1, 1'b0);

        // Image 3: reset at dump byte 12.
        set_img(2);
        load_img(1'b0);
        @(negedge clk);
        halt_signel = 1'b1;
        @(negedge clk);
        halt_signel = 1'b0;
        dump_img(-1, 12, 1'b0);
        #1;
        chk("after_reset_ready", 32'(bus.in_ready), 1);

        // Image 4: fresh load and dump after the reset.
        set_img(3);
        load_img(1'b0);
        @(negedge clk);
        halt_signel = 1'b1;
        @(negedge clk);
        halt_signel = 1'b0;
        dump_img(-1, -1, 1'b0);

        // Image 5: no halt.
        set_img(1);
        load_img(1'b0);
`ifdef LOADER_WATCHDOG_EN
        begin : wdog_blk
            int run = 1;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                #1;
                if (bus.mem_sel == 1'b0) run++;
                else break;
            end
            chk("wdog_run_cycles", 32'(run),     16);
            chk("wdog_timeout",    32'(timeout), 1);
            chk("wdog_cpu_n_rst",  32'(cpu_n_rst), 0);
        end
        dump_img(-1, -1, 1'b1);
`else
        repeat (1100) @(negedge clk);
        #1;
        chk("norun_mem_sel",   32'(bus.mem_sel), 0);
        chk("norun_cpu_n_rst", 32'(cpu_n_rst),   1);
        chk("norun_timeout",   32'(timeout),     0);
        halt_signel = 1'b1;
        @(negedge clk);
        halt_signel = 1'b0;
        #1;
        chk("late_halt_dump", 32'(bus.mem_sel), 1);
        dump_img(-1, -1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_program_loader.md
# cpu_program_loader

Host-side companion to the CPU: it owns the program memory while the CPU is held in reset, fills it from a byte stream, releases the CPU, waits for `halt_signel`, then reclaims memory and streams every location back out. It replaces hand-written testbench stimulus with a single load/run/dump sequence, and can also serve as an on-chip boot/debug front end.

## Interface
- `DATA_WIDTH`, 8: memory word and stream byte width.
- `ADDRESS_WIDTH`, 5: memory address width; image size is `DEPTH = 2**ADDRESS_WIDTH` words.
- `WDOG_CYCLES`, 4096: RUN-state cycle limit, used only when the watchdog is compiled in.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  host byte valid.
- `in_ready`  out  1  loader accepts a byte.
- `in_data`  in  DATA_WIDTH  program byte.
- `out_valid`  out  1  dump byte valid.
- `out_ready`  in  1  host accepts the dump byte.
- `out_data`  out  DATA_WIDTH  dump byte (registered).
- `mem_sel`  out  1  1 = loader drives the memory port; 0 = CPU drives it.
- `mem_addr`  out  ADDRESS_WIDTH  loader memory address.
- `mem_wdata`  out  DATA_WIDTH  loader write data.
- `mem_we`  out  1  loader write strobe.
- `mem_rdata`  in  DATA_WIDTH  memory read data; synchronous, valid 1 cycle after `mem_addr`.
- `cpu_n_rst`  out  1  CPU reset, active-low, driven from a register.
- `halt_signel`  in  1  CPU halt indication.
- `done`  out  1  one-cycle pulse when the dump completes.
- `timeout`  out  1  sticky flag: the watchdog expired during the last run.

## Operation
- States: LOAD, RUN, DUMP_REQ, DUMP_CAP, DUMP_OUT, DONE. Reset enters LOAD.
- Address counter `addr` has ADDRESS_WIDTH bits and wraps from `DEPTH-1` to 0.
- **LOAD**
  - Outputs: `cpu_n_rst`=0, `mem_sel`=1, `in_ready`=1.
  - `mem_we = in_valid & in_ready`, `mem_addr = addr`, `mem_wdata = in_data`; all three are combinational.
  - Each accepted byte increments `addr`.
  - Accepting a byte at `addr = DEPTH-1` moves to RUN, with `addr` wrapping to 0.
- **RUN**
  - Outputs: `cpu_n_rst`=1, `mem_sel`=0, `in_ready`=0.
  - `halt_signel` is ignored in the first RUN cycle, because the CPU is only just leaving reset.
  - From the second cycle onward, `halt_signel`=1 moves to DUMP_REQ.
- **DUMP_REQ**
  - Outputs: `cpu_n_rst`=0, `mem_sel`=1, `mem_addr = addr`, `mem_we`=0.
  - Next state is DUMP_CAP.
- **DUMP_CAP**
  - Registers `mem_rdata` into `out_data`.
  - Next state is DUMP_OUT.
- **DUMP_OUT**
  - `out_valid`=1; `out_data` is held stable until `out_ready`.
  - On `out_valid & out_ready`: if `addr = DEPTH-1`, go to DONE; otherwise increment `addr` and return to DUMP_REQ.
- **DONE**
  - `done`=1 for exactly one cycle, `addr`←0, then LOAD.
  - `timeout` is cleared on the DONE→LOAD transition.
- Boundaries:
  - `in_valid` with the loader in any state other than LOAD: the byte is not accepted, because `in_ready`=0.
  - `halt_signel` in any state other than RUN: ignored.
  - `out_ready` without `out_valid`: ignored.
  - Async reset at any point: state=LOAD, `addr`=0, `cpu_n_rst`=0, `out_valid`=0, `done`=0, `timeout`=0. Memory contents are untouched.
- Reset values of all outputs:
  - `in_ready`=1, `mem_sel`=1, `mem_we`=0 (`in_valid` is low).
  - `mem_addr`=0, `out_data`=0, `out_valid`=0.
  - `cpu_n_rst`=0, `done`=0, `timeout`=0.

## Timing
- Load throughput is 1 byte/cycle; a full image takes `DEPTH` accepted handshakes.
- Last load handshake at edge k: `cpu_n_rst` goes 1 after edge k.
- Halt response: `halt_signel` high before edge h moves the block to DUMP_REQ at h. `cpu_n_rst`=0 and `mem_sel`=1 after edge h.
- Dump latency: DUMP_REQ→DUMP_CAP→DUMP_OUT gives `out_valid` 2 cycles after DUMP_REQ. Minimum 3 cycles per byte with `out_ready` held high.
- `done` asserts the cycle after the final dump handshake.

## Configuration
- `LOADER_WATCHDOG_EN` defined:
  - A cycle counter of width `$clog2(WDOG_CYCLES+1)` clears on RUN entry and counts each RUN cycle.
  - When the count reaches `WDOG_CYCLES` without a halt, the block moves to DUMP_REQ and sets `timeout`=1.
  - If halt and expiry occur in the same cycle, halt wins and `timeout` stays 0.
- Not defined:
  - No counter is built and `timeout` is tied to 0.
  - RUN waits for `halt_signel` indefinitely.

## Test plan
- **Load and dump:** stream bytes `8'hA0+i` for i=0..31 with `in_valid` held high, then hold `halt_signel`=1 from the 3rd RUN cycle.
  - `cpu_n_rst` rises the cycle after byte 31.
  - The dump returns `A0..BF` in order, followed by one `done` pulse.
- **Output backpressure:** hold `out_ready`=0 for 10 cycles during byte 5 of the dump.
  - `out_valid` stays 1 and `out_data` stays stable (`8'hA5`).
  - No byte is skipped or duplicated.
- **Halt gating:**
  - `halt_signel`=1 during LOAD: no state change.
  - `halt_signel`=1 in RUN cycle 1 only: block stays in RUN.
  - `halt_signel`=1 in RUN cycle 2: block enters DUMP_REQ.
- **Reset mid-dump:** assert `n_rst`=0 asynchronously at dump byte 12.
  - Outputs immediately take their reset values.
  - A fresh 32-byte load and dump of new data reads back correctly.
- **Watchdog (`LOADER_WATCHDOG_EN`, `WDOG_CYCLES`=16):** never assert halt.
  - The dump starts after 16 RUN cycles with `timeout`=1.
  - `timeout` clears on DONE→LOAD.
  - Without the macro, RUN persists for more than 1000 cycles.
- **Back-to-back images:** after `done`, load a second image with bytes `8'h5A ^ i`; the second dump matches the second image exactly.
